// File: rtl/axi_slave_mem.sv
// AXI4 slave backed by a word-addressed memory; one transaction at a time, FIXED/INCR bursts of 4-byte beats.
// Optional macro AXI_SLAVE_RD_WAIT_EN inserts a one-cycle rvalid gap after every non-final R handshake.
module axi_slave_mem #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              aclk,
  input  logic              areset_n,
  input  logic [ADDR_W-1:0] araddr,
  input  logic [7:0]        arlen,
  input  logic [2:0]        arsize,
  input  logic [1:0]        arburst,
  input  logic              arvalid,
  output logic              arready,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        rresp,
  output logic              rlast,
  output logic              rvalid,
  input  logic              rready,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic [7:0]        awlen,
  input  logic [2:0]        awsize,
  input  logic [1:0]        awburst,
  input  logic              awvalid,
  output logic              awready,
  input  logic [DATA_W-1:0] wdata,
  input  logic [3:0]        wstrb,
  input  logic              wlast,
  input  logic              wvalid,
  output logic              wready,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int WI_W  = ADDR_W - 2;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  typedef enum logic [1:0] {IDLE, RDATA, WDATA, WRESP} state_t;

  // Every channel handshake completes on a rising edge where its valid and ready are both 1.
  state_t            state_q, state_d;
  logic [WI_W-1:0]   idx_q, idx_d;
  logic [7:0]        len_q, len_d;
  logic [7:0]        beat_q, beat_d;
  logic [1:0]        burst_q, burst_d;
  logic              bad_q, bad_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        rresp_q, rresp_d;
  logic              rlast_q, rlast_d;
  logic [1:0]        bresp_q, bresp_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
`ifdef AXI_SLAVE_RD_WAIT_EN
  logic              gap_q, gap_d;
`endif

  logic ar_hs, aw_hs, r_hs, w_hs, b_hs;
  logic [WI_W-1:0]   cur_start, cur_idx;
  logic [1:0]        cur_burst;
  logic              cur_bad, cur_ok, cur_last;
  logic [7:0]        cur_n, cur_len;
  logic [DATA_W-1:0] cur_rdata;
  logic              unused_addr_lsbs;

  assign unused_addr_lsbs = ^{araddr[1:0], awaddr[1:0]};

  function automatic logic burst_bad(input logic [1:0] burst, input logic [2:0] size);
    return burst[1] || (size != 3'b010);
  endfunction

  assign ar_hs = arvalid && arready;
  assign aw_hs = awvalid && awready;
  assign r_hs  = rvalid && rready;
  assign w_hs  = wvalid && wready;
  assign b_hs  = bvalid && bready;

  // Beat being addressed: beat 0 of an incoming read in IDLE, the next read beat in RDATA,
  // the current write beat in WDATA.
  always_comb begin
    if (state_q == IDLE) begin
      cur_start = araddr[ADDR_W-1:2];
      cur_burst = arburst;
      cur_bad   = burst_bad(arburst, arsize);
      cur_n     = 8'd0;
      cur_len   = arlen;
    end else begin
      cur_start = idx_q;
      cur_burst = burst_q;
      cur_bad   = bad_q;
      cur_n     = (state_q == RDATA) ? beat_q + 8'd1 : beat_q;
      cur_len   = len_q;
    end
    cur_idx   = (cur_burst == BURST_INCR) ? cur_start + WI_W'(cur_n) : cur_start;
    cur_ok    = !cur_bad && (cur_idx < WI_W'(DEPTH));
    cur_last  = (cur_n == cur_len);
    cur_rdata = '0;
    if (cur_ok) cur_rdata = mem_q[cur_idx[IDX_W-1:0]];
  end

  always_ff @(posedge aclk) begin
    if (!areset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      burst_q <= '0;
      bad_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      rresp_q <= '0;
      rlast_q <= 1'b0;
      bresp_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
`ifdef AXI_SLAVE_RD_WAIT_EN
      gap_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      burst_q <= burst_d;
      bad_q   <= bad_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      rresp_q <= rresp_d;
      rlast_q <= rlast_d;
      bresp_q <= bresp_d;
      mem_q   <= mem_d;
`ifdef AXI_SLAVE_RD_WAIT_EN
      gap_q   <= gap_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ar_hs) state_d = RDATA;
               else if (aw_hs) state_d = WDATA;
      RDATA:   if (r_hs && rlast_q) state_d = IDLE;
      WDATA:   if (w_hs && cur_last) state_d = WRESP;
      WRESP:   if (b_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    idx_d   = idx_q;
    len_d   = len_q;
    beat_d  = beat_q;
    burst_d = burst_q;
    bad_d   = bad_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    rresp_d = rresp_q;
    rlast_d = rlast_q;
    bresp_d = bresp_q;
    mem_d   = mem_q;
`ifdef AXI_SLAVE_RD_WAIT_EN
    gap_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (ar_hs) begin
          idx_d   = araddr[ADDR_W-1:2];
          len_d   = arlen;
          burst_d = arburst;
          bad_d   = cur_bad;
          beat_d  = 8'd0;
          err_d   = 1'b0;
          rdata_d = cur_rdata;
          rresp_d = cur_ok ? RESP_OKAY : RESP_SLVERR;
          rlast_d = cur_last;
        end else if (aw_hs) begin
          idx_d   = awaddr[ADDR_W-1:2];
          len_d   = awlen;
          burst_d = awburst;
          bad_d   = burst_bad(awburst, awsize);
          beat_d  = 8'd0;
          err_d   = 1'b0;
        end
      end
      RDATA: begin
        if (r_hs && !rlast_q) begin
          beat_d  = beat_q + 8'd1;
          rdata_d = cur_rdata;
          rresp_d = cur_ok ? RESP_OKAY : RESP_SLVERR;
          rlast_d = cur_last;
`ifdef AXI_SLAVE_RD_WAIT_EN
          gap_d   = 1'b1;
`endif
        end
      end
      WDATA: begin
        if (w_hs) begin
          if (cur_ok) begin
            for (int i = 0; i < 4; i++) begin
              if (wstrb[i]) mem_d[cur_idx[IDX_W-1:0]][8*i +: 8] = wdata[8*i +: 8];
            end
          end
          // wlast only flags a protocol error; the beat count alone ends the burst.
          err_d = err_q || !cur_ok || (wlast != cur_last);
          if (cur_last) bresp_d = err_d ? RESP_SLVERR : RESP_OKAY;
          else          beat_d  = beat_q + 8'd1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    arready = areset_n && (state_q == IDLE);
    awready = areset_n && (state_q == IDLE) && !arvalid;
`ifdef AXI_SLAVE_RD_WAIT_EN
    rvalid  = areset_n && (state_q == RDATA) && !gap_q;
`else
    rvalid  = areset_n && (state_q == RDATA);
`endif
    wready  = areset_n && (state_q == WDATA);
    bvalid  = areset_n && (state_q == WRESP);
    rdata   = rdata_q;
    rresp   = rresp_q;
    rlast   = rlast_q;
    bresp   = bresp_q;
  end

endmodule

// File: tb/tb_axi_slave_mem.sv
// Directed bench for axi_slave_mem: memory/response model with expected queues, per-cycle R/B compare,
// plus literal expectations for the key data patterns.
module tb_axi_slave_mem;
  localparam int DEPTH  = 64;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic              aclk = 1'b0;
  logic              areset_n = 1'b0;
  logic [ADDR_W-1:0] araddr = '0, awaddr = '0;
  logic [7:0]        arlen = '0, awlen = '0;
  logic [2:0]        arsize = '0, awsize = '0;
  logic [1:0]        arburst = '0, awburst = '0;
  logic              arvalid = 1'b0, awvalid = 1'b0;
  logic              arready, awready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp, bresp;
  logic              rlast, rvalid, bvalid, wready;
  logic              rready = 1'b0, bready = 1'b0;
  logic [DATA_W-1:0] wdata = '0;
  logic [3:0]        wstrb = '0;
  logic              wlast = 1'b0, wvalid = 1'b0;

  axi_slave_mem #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .aclk(aclk), .areset_n(areset_n),
    .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  // clock
  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_mem [DEPTH];
  logic [34:0] exp_q[$];
  logic [1:0]  exp_b_q[$];
  logic [31:0] wd [256];
  logic [31:0] cap_data [256];
  logic [1:0]  cap_resp [256];
  int          cap_n = 0;
  logic [1:0]  b_cap = 2'b11;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  function automatic bit wlast_for(input int i, input int len, input int mode);
    if (mode == 1) return 1'b1;
    if (mode == 2) return 1'b0;
    return (i == len);
  endfunction

  function automatic int beat_idx(input logic [31:0] addr, input logic [1:0] burst, input int i);
    return (burst == 2'b01) ? int'(addr >> 2) + i : int'(addr >> 2);
  endfunction

  // model
  task automatic model_write(input logic [31:0] addr, input int len, input logic [1:0] burst,
                             input logic [2:0] size, input logic [3:0] strb, input int wl_mode);
    bit bad = (burst >= 2'b10) || (size != 3'b010);
    bit err = 1'b0;
    for (int i = 0; i <= len; i++) begin
      int idx = beat_idx(addr, burst, i);
      bit ok = !bad && (idx < DEPTH);
      if (ok) for (int b = 0; b < 4; b++) if (strb[b]) exp_mem[idx][8*b +: 8] = wd[i][8*b +: 8];
      if (!ok) err = 1'b1;
      if (wlast_for(i, len, wl_mode) != (i == len)) err = 1'b1;
    end
    exp_b_q.push_back(err ? 2'b10 : 2'b00);
  endtask

  task automatic model_read(input logic [31:0] addr, input int len, input logic [1:0] burst,
                            input logic [2:0] size);
    bit bad = (burst >= 2'b10) || (size != 3'b010);
    for (int i = 0; i <= len; i++) begin
      int idx = beat_idx(addr, burst, i);
      bit ok = !bad && (idx < DEPTH);
      logic [31:0] d = ok ? exp_mem[idx] : 32'h0;
      exp_q.push_back({(i == len), (ok ? 2'b00 : 2'b10), d});
    end
  endtask

  // per-cycle compare of R and B channels
  logic        hold_pend = 1'b0;
  logic [31:0] hold_data;
  logic [1:0]  hold_resp;
  logic        hold_last;
  logic [34:0] e;
  logic [1:0]  eb;

  always @(negedge aclk) begin
    if (!areset_n) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        check("r_hold_valid", rvalid, 1);
        check("r_hold_data", rdata, hold_data);
        check("r_hold_resp", rresp, hold_resp);
        check("r_hold_last", rlast, hold_last);
      end
      hold_pend = rvalid && !rready;
      hold_data = rdata;
      hold_resp = rresp;
      hold_last = rlast;
      if (rvalid && rready) begin
        if (exp_q.size() == 0) check("r_unexpected", exp_q.size(), 1);
        else begin
          e = exp_q.pop_front();
          check("r_data", rdata, e[31:0]);
          check("r_resp", rresp, e[33:32]);
          check("r_last", rlast, e[34]);
          cap_data[cap_n] = rdata;
          cap_resp[cap_n] = rresp;
          cap_n++;
        end
      end
      if (bvalid && bready) begin
        if (exp_b_q.size() == 0) check("b_unexpected", exp_b_q.size(), 1);
        else begin
          eb = exp_b_q.pop_front();
          check("b_resp", bresp, eb);
          b_cap = bresp;
        end
      end
    end
  end

  // driver tasks
  task automatic ar_phase(input logic [31:0] addr, input int len, input logic [1:0] burst,
                          input logic [2:0] size, input bit chk_aw);
    bit hs = 1'b0;
    int n = 0;
    araddr = addr; arlen = 8'(len); arburst = burst; arsize = size; arvalid = 1'b1;
    while (!hs && n < 50) begin
      @(negedge aclk);
      if (chk_aw && n == 0) check("aw_lose_contention", awready, 0);
      hs = arready;
      tick();
      n++;
    end
    arvalid = 1'b0;
    check("ar_handshake", hs, 1);
  endtask

  task automatic aw_phase(input logic [31:0] addr, input int len, input logic [1:0] burst,
                          input logic [2:0] size);
    bit hs = 1'b0;
    int n = 0;
    awaddr = addr; awlen = 8'(len); awburst = burst; awsize = size; awvalid = 1'b1;
    while (!hs && n < 50) begin
      @(negedge aclk);
      hs = awready;
      tick();
      n++;
    end
    awvalid = 1'b0;
    check("aw_handshake", hs, 1);
  endtask

  task automatic w_phase(input int len, input logic [3:0] strb, input int wl_mode);
    for (int i = 0; i <= len; i++) begin
      bit hs = 1'b0;
      int n = 0;
      wvalid = 1'b1; wdata = wd[i]; wstrb = strb; wlast = wlast_for(i, len, wl_mode);
      while (!hs && n < 50) begin
        @(negedge aclk);
        hs = wready;
        tick();
        n++;
      end
      check("w_handshake", hs, 1);
    end
    wvalid = 1'b0;
    wlast = 1'b0;
  endtask

  task automatic b_phase();
    bit hs;
    int n = 1;
    bready = 1'b1;
    @(negedge aclk);
    check("b_latency", bvalid, 1);
    hs = bvalid;
    tick();
    while (!hs && n < 50) begin
      @(negedge aclk);
      hs = bvalid;
      tick();
      n++;
    end
    check("b_handshake", hs, 1);
    bready = 1'b0;
  endtask

  task automatic r_phase(input int len, input int stall_at, input int stall_n, input bit chk_aw);
    int beats = 0;
    int cycles = 0;
    bit first = 1'b1;
    bit hs;
    int exp_cycles;
    cap_n = 0;
    rready = 1'b1;
    while (beats <= len && cycles < 2000) begin
      @(negedge aclk);
      if (first) check("r_first_latency", rvalid, 1);
      first = 1'b0;
      if (chk_aw) check("aw_blocked", awready, 0);
      hs = rvalid && rready;
      tick();
      cycles++;
      if (hs) begin
        beats++;
        if (beats == stall_at && stall_n > 0 && beats <= len) begin
          rready = 1'b0;
          repeat (stall_n) begin
            @(negedge aclk);
            if (chk_aw) check("aw_blocked", awready, 0);
            tick();
            cycles++;
          end
          rready = 1'b1;
        end
      end
    end
    check("r_beats", beats, len + 1);
`ifdef AXI_SLAVE_RD_WAIT_EN
    exp_cycles = 2 * len + 1;
`else
    exp_cycles = len + 1;
`endif
    if (stall_n == 0) check("r_cycles", cycles, exp_cycles);
    @(negedge aclk);
    check("r_drop", rvalid, 0);
    if (chk_aw) check("aw_after_read", awready, 1);
    rready = 1'b0;
    tick();
  endtask

  task automatic do_write(input logic [31:0] addr, input int len, input logic [1:0] burst,
                          input logic [2:0] size, input logic [3:0] strb, input int wl_mode);
    model_write(addr, len, burst, size, strb, wl_mode);
    aw_phase(addr, len, burst, size);
    w_phase(len, strb, wl_mode);
    b_phase();
  endtask

  task automatic do_read(input logic [31:0] addr, input int len, input logic [1:0] burst,
                         input logic [2:0] size);
    model_read(addr, len, burst, size);
    ar_phase(addr, len, burst, size, 1'b0);
    r_phase(len, 0, 0, 1'b0);
  endtask

  initial begin
    bit hs;
    int n;
    foreach (exp_mem[i]) exp_mem[i] = '0;

    // reset
    repeat (3) tick();
    @(negedge aclk);
    check("rst_arready", arready, 0);
    check("rst_awready", awready, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_wready", wready, 0);
    check("rst_bvalid", bvalid, 0);
    tick();
    areset_n = 1'b1;
    @(negedge aclk);
    check("idle_arready", arready, 1);
    check("idle_awready", awready, 1);
    check("rst_rdata", rdata, 0);
    check("rst_rresp", rresp, 0);
    check("rst_rlast", rlast, 0);
    check("rst_bresp", bresp, 0);
    tick();

    // INCR write then read, 4 beats at 0x4
    for (int i = 0; i < 4; i++) wd[i] = 32'hdeadbeef + i;
    do_write(32'h4, 3, 2'b01, 3'b010, 4'hF, 0);
    check("lit_bresp_okay", b_cap, 2'b00);
    do_read(32'h4, 3, 2'b01, 3'b010);
    check("lit_rd0", cap_data[0], 32'hdeadbeef);
    check("lit_rd3", cap_data[3], 32'hdeadbef2);

    // partial strobe, FIXED
    wd[0] = 32'h12345678;
    do_write(32'h4, 0, 2'b00, 3'b010, 4'b0011, 0);
    do_read(32'h4, 0, 2'b00, 3'b010);
    check("lit_partial", cap_data[0], 32'hdead5678);

    // FIXED multi-beat: last beat wins, reads repeat one word
    wd[0] = 32'h11111111; wd[1] = 32'h22222222;
    do_write(32'h10, 1, 2'b00, 3'b010, 4'hF, 0);
    do_read(32'h10, 2, 2'b00, 3'b010);
    check("lit_fixed", cap_data[2], 32'h22222222);

    // out-of-range beats at the top of memory
    for (int i = 0; i < 4; i++) wd[i] = 32'hcafe0000 + i;
    do_write(32'hF8, 3, 2'b01, 3'b010, 4'hF, 0);
    check("lit_oor_bresp", b_cap, 2'b10);
    do_read(32'hF8, 3, 2'b01, 3'b010);
    check("lit_oor_d0", cap_data[0], 32'hcafe0000);
    check("lit_oor_d1", cap_data[1], 32'hcafe0001);
    check("lit_oor_r1", cap_resp[1], 2'b00);
    check("lit_oor_r2", cap_resp[2], 2'b10);
    check("lit_oor_d3", cap_data[3], 32'h0);

    // illegal burst types and sizes
    wd[0] = 32'hbad0bad0; wd[1] = 32'hbad1bad1;
    do_write(32'h4, 1, 2'b10, 3'b010, 4'hF, 0);
    check("lit_wrap_bresp", b_cap, 2'b10);
    do_write(32'h4, 0, 2'b01, 3'b001, 4'hF, 0);
    do_read(32'h4, 0, 2'b01, 3'b010);
    check("lit_wrap_unchanged", cap_data[0], 32'hdead5678);
    do_read(32'h8, 1, 2'b11, 3'b010);
    do_read(32'h8, 0, 2'b01, 3'b000);

    // wlast mismatch: data lands, response is SLVERR
    wd[0] = 32'h0a0a0a0a; wd[1] = 32'h0b0b0b0b;
    do_write(32'h20, 1, 2'b01, 3'b010, 4'hF, 1);
    check("lit_early_wlast", b_cap, 2'b10);
    do_write(32'h28, 1, 2'b01, 3'b010, 4'hF, 2);
    do_read(32'h20, 3, 2'b01, 3'b010);

    // read/write contention with backpressure
    wd[0] = 32'h77770000; wd[1] = 32'h77770001;
    model_read(32'h4, 3, 2'b01, 3'b010);
    model_write(32'h40, 1, 2'b01, 3'b010, 4'hF, 0);
    awaddr = 32'h40; awlen = 8'd1; awburst = 2'b01; awsize = 3'b010; awvalid = 1'b1;
    ar_phase(32'h4, 3, 2'b01, 3'b010, 1'b1);
    r_phase(3, 2, 3, 1'b1);
    awvalid = 1'b0;
    w_phase(1, 4'hF, 0);
    b_phase();
    do_read(32'h40, 1, 2'b01, 3'b010);
    check("lit_contention_wr", cap_data[1], 32'h77770001);

    // 256-beat burst
    do_read(32'h0, 255, 2'b01, 3'b010);
    check("lit_long_tail", cap_resp[255], 2'b10);

    // reset in the middle of a write burst
    for (int i = 0; i < 4; i++) wd[i] = 32'h5a5a0000 + i;
    aw_phase(32'h0, 3, 2'b01, 3'b010);
    wvalid = 1'b1; wdata = wd[0]; wstrb = 4'hF; wlast = 1'b0;
    hs = 1'b0; n = 0;
    while (!hs && n < 50) begin
      @(negedge aclk);
      hs = wready;
      tick();
      n++;
    end
    check("w_handshake", hs, 1);
    wdata = wd[1];
    areset_n = 1'b0;
    @(negedge aclk);
    check("mid_rst_wready", wready, 0);
    check("mid_rst_arready", arready, 0);
    tick();
    @(negedge aclk);
    check("mid_rst_rvalid", rvalid, 0);
    check("mid_rst_wready2", wready, 0);
    check("mid_rst_bvalid", bvalid, 0);
    wvalid = 1'b0;
    tick();
    areset_n = 1'b1;
    foreach (exp_mem[i]) exp_mem[i] = '0;
    @(negedge aclk);
    check("post_rst_arready", arready, 1);
    check("post_rst_awready", awready, 1);
    tick();
    do_read(32'h0, 4, 2'b01, 3'b010);
    check("lit_rst_cleared", cap_data[0], 32'h0);
    check("lit_rst_cleared1", cap_data[1], 32'h0);

    check("r_queue_drained", exp_q.size(), 0);
    check("b_queue_drained", exp_b_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: got running expected done");
    $fatal(1, "timeout");
  end

endmodule
